// File: rtl/image_load_sequencer.sv
// rtl/image_load_sequencer.sv - sequences one image load from the Pi into the frame buffer over the PI_STATE/FPGA_STATE handshake.
// Optional watchdog on WAIT_READY/ACK is compiled in with `define IMG_LOAD_TIMEOUT_EN.
module image_load_sequencer #(
   parameter int IMG_BYTES      = 784,
   parameter int BLOCK_BYTES    = 4,
   parameter int ADDR_W         = 10,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              classifier_busy,
   input  logic [1:0]        PI_STATE,
   input  logic [7:0]        pi_data,
   output logic [1:0]        FPGA_STATE,
   output logic              buf_we,
   output logic [ADDR_W-1:0] buf_addr,
   output logic [7:0]        buf_wdata,
   output logic              image_valid,
   output logic              busy,
   output logic              err
);

   // idx must be able to hold IMG_BYTES itself, which may equal 2^ADDR_W
   localparam int IDX_W = ADDR_W + 1;
   localparam int BLK_W = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
   localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(IMG_BYTES);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(IMG_BYTES - 1);
   localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLOCK_BYTES - 1);

   localparam logic [1:0] PI_READY    = 2'b01;
   localparam logic [1:0] PI_CONTINUE = 2'b11;
   localparam logic [1:0] PI_DONE     = 2'b10;

   localparam logic [1:0] FS_IDLE       = 2'b11;
   localparam logic [1:0] FS_READING    = 2'b10;
   localparam logic [1:0] FS_DONE_BLOCK = 2'b01;
   localparam logic [1:0] FS_DONE_ALL   = 2'b00;

   if (IMG_BYTES < 1 || BLOCK_BYTES < 1 || (2 ** ADDR_W) < IMG_BYTES || TIMEOUT_CYCLES < 1) begin : gBadParams
      $error("image_load_sequencer: invalid parameter set");
   end

   typedef enum logic [2:0] {
      IDLE,
      WAIT_READY,
      CAPTURE,
      ACK,
      COMPLETE,
      ERROR
   } stateType;

   stateType         state;
   stateType         nextState;
   logic [IDX_W-1:0] idx;
   logic [BLK_W-1:0] blk;
   logic             timeout;

`ifdef IMG_LOAD_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   logic [WD_W-1:0] watchdog;
   logic            waiting;

   assign waiting = (state == WAIT_READY) || (state == ACK);

   // Counts across ACK->WAIT_READY; only CAPTURE or leaving the load clears it
   always_ff @(posedge clk) begin
      if (reset || !waiting) begin
         watchdog <= '0;
      end else begin
         watchdog <= watchdog + 1'b1;
      end
   end

   assign timeout = waiting && (watchdog == WD_LAST);
`else
   assign timeout = 1'b0;
`endif

   assign buf_wdata = pi_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx <= '0;
         blk <= '0;
         err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (nextState == WAIT_READY) begin
                  idx <= '0;
                  blk <= '0;
                  err <= 1'b0;
               end
            end
            CAPTURE: begin
               idx <= idx + 1'b1;
               blk <= (nextState == ACK) ? '0 : blk + 1'b1;
            end
            default: begin
            end
         endcase
         if (nextState == ERROR) begin
            err <= 1'b1;
         end
      end
   end

   always_comb begin
      nextState   = state;
      FPGA_STATE  = FS_IDLE;
      buf_we      = 1'b0;
      buf_addr    = '0;
      image_valid = 1'b0;
      busy        = 1'b0;
      case (state)
         IDLE: begin
            if (start && !classifier_busy) begin
               nextState = WAIT_READY;
            end
         end
         WAIT_READY: begin
            busy = 1'b1;
            if (timeout) begin
               nextState = ERROR;
            end else if (PI_STATE == PI_READY) begin
               nextState = CAPTURE;
            end
         end
         CAPTURE: begin
            busy       = 1'b1;
            FPGA_STATE = FS_READING;
            // a reset edge aborts the load, so the byte on that edge is not written
            buf_we     = !reset;
            buf_addr   = idx[ADDR_W-1:0];
            if (blk == BLK_LAST || idx == IDX_LAST) begin
               nextState = ACK;
            end
         end
         ACK: begin
            busy       = 1'b1;
            FPGA_STATE = FS_DONE_BLOCK;
            if (timeout) begin
               nextState = ERROR;
            end else if (PI_STATE == PI_CONTINUE) begin
               nextState = (idx < IDX_FULL) ? WAIT_READY : ERROR;
            end else if (PI_STATE == PI_DONE) begin
               nextState = (idx == IDX_FULL) ? COMPLETE : ERROR;
            end
         end
         COMPLETE: begin
            busy        = 1'b1;
            FPGA_STATE  = FS_DONE_ALL;
            image_valid = 1'b1;
            nextState   = IDLE;
         end
         ERROR: begin
            nextState = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

endmodule

// File: doc/image_load_sequencer.md
# image_load_sequencer

Controller that sequences the loading of one 28x28 8-bit image from the Raspberry Pi into the classifier frame buffer over the existing 2-bit PI_STATE / FPGA_STATE block handshake. It counts bytes, generates frame-buffer write strobes and addresses, and detects protocol errors. On a complete image it pulses `image_valid` to the classifier, and it refuses new loads while the classifier holds the buffer. It sits between the GPIO pin interface and the frame buffer/classifier.

## Interface
Parameters:
- `IMG_BYTES`, 784, bytes per image
- `BLOCK_BYTES`, 4, bytes captured per READY handshake
- `ADDR_W`, 10, frame-buffer address width (must satisfy 2^ADDR_W >= IMG_BYTES)
- `TIMEOUT_CYCLES`, 1000000, watchdog limit (used only with `IMG_LOAD_TIMEOUT_EN`)

Ports:
- `clk`  in  1  single clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  request to load one image
- `classifier_busy`  in  1  classifier is reading the frame buffer; loads are blocked
- `PI_STATE`  in  2  Pi state: BUSY=00, READY=01, CONTINUE=11, DONE=10
- `pi_data`  in  8  image byte from the Pi
- `FPGA_STATE`  out  2  IDLE=11, READING=10, DONE_READING_BLOCK=01, DONE_READING_ALL=00
- `buf_we`  out  1  frame-buffer write enable
- `buf_addr`  out  ADDR_W  frame-buffer write address
- `buf_wdata`  out  8  frame-buffer write data; combinational copy of `pi_data`
- `image_valid`  out  1  one-cycle pulse when the full image is written
- `busy`  out  1  load in progress
- `err`  out  1  sticky protocol or timeout error

## Operation
- Registers: `state`, byte index `idx` (0..IMG_BYTES), block counter `blk` (0..BLOCK_BYTES-1), `err`, and the watchdog counter.
- **IDLE** (FPGA_STATE=11):
  - `start && !classifier_busy` -> WAIT_READY; clear `idx`, `blk`, `err`.
  - `start` while `classifier_busy` is ignored. No request is queued.
- **WAIT_READY** (FPGA_STATE=11):
  - `PI_STATE==READY` -> CAPTURE.
  - Any other PI_STATE value: stay.
- **CAPTURE** (FPGA_STATE=10):
  - Every cycle: `buf_we=1`, `buf_addr=idx`, increment `idx` and `blk`.
  - Leave for ACK after the cycle with `blk==BLOCK_BYTES-1` or `idx==IMG_BYTES-1`; `blk` returns to 0.
  - PI_STATE is not examined during CAPTURE.
- **ACK** (FPGA_STATE=01):
  - `PI_STATE==CONTINUE`: go to WAIT_READY if `idx<IMG_BYTES`; otherwise go to ERROR (overrun).
  - `PI_STATE==DONE`: go to COMPLETE if `idx==IMG_BYTES`; otherwise go to ERROR (underrun).
  - BUSY or READY: stay.
- **COMPLETE** (FPGA_STATE=00): one cycle, `image_valid=1`, then -> IDLE.
- **ERROR** (FPGA_STATE=11): one cycle, set `err`, then -> IDLE. No further writes occur.
- `busy=1` in WAIT_READY, CAPTURE, ACK and COMPLETE.
- `err` holds until the next accepted `start` or `reset`.
- Bytes already written before an error stay in the buffer. `image_valid` is not pulsed for that load.
- `idx` never exceeds IMG_BYTES, and `buf_addr` never exceeds IMG_BYTES-1 while `buf_we=1`.
- A final block shorter than BLOCK_BYTES is legal; IMG_BYTES need not be a multiple of BLOCK_BYTES.

## Timing
- `reset` is sampled at the clock edge. One asserted edge gives:
  - state=IDLE, FPGA_STATE=11
  - `buf_we=0`, `buf_addr=0`, `image_valid=0`, `busy=0`, `err=0`
  - `idx=0`, `blk=0`, watchdog=0
- `reset` asserted mid-load aborts immediately. No write occurs in the reset cycle, and the next load restarts at address 0.
- `start` accepted at edge k gives WAIT_READY from k+1. If READY is already present, CAPTURE runs from k+2.
- CAPTURE writes `pi_data` on the edges where `buf_we=1`: one byte per cycle, BLOCK_BYTES consecutive cycles.
- Minimum block cost is 1 WAIT_READY + BLOCK_BYTES CAPTURE + 1 ACK cycles (6 at defaults). A full image takes 196 blocks, i.e. at least 1176 cycles plus COMPLETE.
- `image_valid` is asserted in the cycle after ACK samples DONE. It is coincident with FPGA_STATE=00.
- A `start` arriving during COMPLETE is ignored. It is accepted from the following IDLE cycle.

## Configuration
- Macro: `IMG_LOAD_TIMEOUT_EN`.
- **Defined:**
  - The watchdog counts every consecutive cycle spent in WAIT_READY or ACK, and resets on entering CAPTURE or IDLE.
  - Reaching TIMEOUT_CYCLES -> ERROR, so `err=1` and the sequencer returns to IDLE.
- **Undefined:**
  - The watchdog logic is absent, and WAIT_READY and ACK wait indefinitely.
  - `err` arises only from overrun or underrun.

## Test plan
- Nominal load: reset, pulse `start`, Pi drives READY/CONTINUE for 196 blocks, `pi_data=addr[7:0]`, then DONE -> 784 writes to addresses 0..783 with matching data, one `image_valid` pulse, `err=0`, FPGA_STATE=00 for exactly one cycle.
- Underrun: DONE after block 10 (idx=40) -> ERROR, `err=1`, no `image_valid`, FPGA_STATE returns to 11.
- Overrun: CONTINUE after the final block (idx=784) -> `err=1`, no write with address >783.
- Blocked start: `classifier_busy=1` with `start` pulsed -> stays IDLE, `busy=0`; deassert `busy`, pulse `start` -> load begins at address 0.
- Reset mid-load: assert `reset` during CAPTURE at idx=402 -> next cycle `buf_we=0`, FPGA_STATE=11; a new load writes from address 0.
- Timeout (`IMG_LOAD_TIMEOUT_EN`, `TIMEOUT_CYCLES=100`): hold PI_STATE=BUSY in WAIT_READY for 100 cycles -> `err=1`, IDLE. Without the macro: still WAIT_READY after 10000 cycles, `err=0`.
